sv32_itrans: RTL and testbench



---
 rtl/sv32_itrans.sv | 216 +++++++++++++++++++++
 tb/tb_sv32_itrans.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sv32_itrans.sv
// rtl/sv32_itrans.sv - SV32 translation responder: small fully associative TLB plus two-level page-table walker
// Single outstanding PTE read; faults are reported but never cached, and A/D bits are never written back.
module sv32_itrans #(
   parameter int TLB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mmu_vaddr_i,
   input  logic        mmu_req_valid_i,
   input  logic        mmu_is_store_i,
   input  logic        mmu_is_inst_i,
   input  logic        mmu_priv_u_i,
   output logic [31:0] mmu_paddr_o,
   output logic        mmu_resp_valid_o,
   output logic        mmu_page_fault_o,
   input  logic        mmu_enable_i,
   input  logic [21:0] mmu_satp_ppn_i,
   input  logic [8:0]  mmu_satp_asid_i,
   input  logic        mmu_mxr_i,
   input  logic        mmu_sum_i,
   output logic        mmu_mem_req_o,
   output logic [31:0] mmu_mem_addr_o,
   input  logic [31:0] mmu_mem_rdata_i,
   input  logic        mmu_mem_rvalid_i,
   input  logic        mmu_flush_i
);
   localparam int IW = $clog2(TLB_ENTRIES);

   typedef enum logic [2:0] {S_IDLE, S_WALK1, S_WALK0, S_DRAIN, S_RESP} state_e;

   state_e        state_q, state_d;
   logic [31:0]   vaddr_q;
   logic          is_store_q, is_inst_q, priv_u_q;
   logic [19:0]   satp_ppn_q;
   logic [8:0]    asid_q;
   logic [19:0]   pte_ppn_q, pte_ppn_d;
   logic [31:0]   paddr_q, paddr_d;
   logic          fault_q, fault_d;
   logic          fill;

   logic          tlb_valid_q [TLB_ENTRIES];
   logic [19:0]   tlb_vpn_q   [TLB_ENTRIES];
   logic [8:0]    tlb_asid_q  [TLB_ENTRIES];
   logic          tlb_g_q     [TLB_ENTRIES];
   logic          tlb_sp_q    [TLB_ENTRIES];
   logic [19:0]   tlb_ppn_q   [TLB_ENTRIES];
   logic [5:0]    tlb_perm_q  [TLB_ENTRIES];
   logic [IW-1:0] rr_q;

   logic          accept, hit, has_inv;
   logic [IW-1:0] hit_idx, inv_idx, victim;
   logic [31:0]   hit_paddr, leaf_paddr, pte;
   logic          hit_fault, leaf_fault, pte_bad, pte_leaf, walk_l1;
   logic [5:0]    pte_perm;
   logic          unused_bits;

   // perm layout {D, A, U, X, W, R}; returns 1 when the access must fault
   function automatic logic perm_fault(input logic [5:0] perm, input logic st, input logic inst,
                                       input logic pu, input logic mxr, input logic sum);
      logic r, w, x, u, a, d;
      {d, a, u, x, w, r} = perm;
      perm_fault = !a || (st && !d) || (inst && !x) || (!inst && !st && !(r || (x && mxr)))
                   || (st && !w) || (pu && !u) || (!pu && u && (inst || !sum));
   endfunction

   assign accept = (state_q == S_IDLE) && mmu_req_valid_i;

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (tlb_valid_q[i]
             && tlb_vpn_q[i][19:10] == mmu_vaddr_i[31:22]
             && (tlb_sp_q[i] || tlb_vpn_q[i][9:0] == mmu_vaddr_i[21:12])
             && (tlb_g_q[i] || tlb_asid_q[i] == mmu_satp_asid_i)) begin
            hit     = !mmu_flush_i;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      has_inv = 1'b0;
      inv_idx = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (!tlb_valid_q[i]) begin
            has_inv = 1'b1;
            inv_idx = IW'(i);
         end
      end
   end

   assign victim    = has_inv ? inv_idx : rr_q;
   assign hit_paddr = tlb_sp_q[hit_idx] ? {tlb_ppn_q[hit_idx][19:10], mmu_vaddr_i[21:0]}
                                        : {tlb_ppn_q[hit_idx], mmu_vaddr_i[11:0]};
   assign hit_fault = perm_fault(tlb_perm_q[hit_idx], mmu_is_store_i, mmu_is_inst_i,
                                 mmu_priv_u_i, mmu_mxr_i, mmu_sum_i);

   assign pte        = mmu_mem_rdata_i;
   assign pte_perm   = {pte[7], pte[6], pte[4], pte[3], pte[2], pte[1]};
   assign pte_bad    = !pte[0] || (!pte[1] && pte[2]);
   assign pte_leaf   = pte[1] || pte[3];
   assign walk_l1    = (state_q == S_WALK1);
   // a level-1 leaf is a superpage and must have PPN[9:0] clear
   assign leaf_fault = (walk_l1 && pte[19:10] != 10'd0)
                       || perm_fault(pte_perm, is_store_q, is_inst_q, priv_u_q, mmu_mxr_i, mmu_sum_i);
   assign leaf_paddr = walk_l1 ? {pte[29:20], vaddr_q[21:0]} : {pte[29:10], vaddr_q[11:0]};
   assign unused_bits = ^{mmu_satp_ppn_i[21:20], pte[31:30], pte[9:8]};

   always_comb begin
      state_d   = state_q;
      paddr_d   = paddr_q;
      fault_d   = fault_q;
      pte_ppn_d = pte_ppn_q;
      fill      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mmu_req_valid_i) begin
               if (!mmu_enable_i) begin
                  paddr_d = mmu_vaddr_i;
                  fault_d = 1'b0;
                  state_d = S_RESP;
               end else if (hit) begin
                  fault_d = hit_fault;
                  paddr_d = hit_fault ? '0 : hit_paddr;
                  state_d = S_RESP;
               end else begin
                  state_d = S_WALK1;
               end
            end
         end
         S_WALK1, S_WALK0: begin
            if (mmu_flush_i) begin
               state_d = mmu_mem_rvalid_i ? S_IDLE : S_DRAIN;
            end else if (mmu_mem_rvalid_i) begin
               state_d = S_RESP;
               fault_d = 1'b1;
               paddr_d = '0;
               if (!pte_bad && pte_leaf) begin
                  fault_d = leaf_fault;
                  if (!leaf_fault) begin
                     paddr_d = leaf_paddr;
                     fill    = 1'b1;
                  end
               end else if (!pte_bad && walk_l1) begin
                  pte_ppn_d = pte[29:10];
                  state_d   = S_WALK0;
               end
            end
         end
         S_DRAIN: begin
            if (mmu_mem_rvalid_i) state_d = S_IDLE;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         vaddr_q    <= '0;
         is_store_q <= 1'b0;
         is_inst_q  <= 1'b0;
         priv_u_q   <= 1'b0;
         satp_ppn_q <= '0;
         asid_q     <= '0;
         pte_ppn_q  <= '0;
         paddr_q    <= '0;
         fault_q    <= 1'b0;
         rr_q       <= '0;
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            tlb_valid_q[i] <= 1'b0;
            tlb_vpn_q[i]   <= '0;
            tlb_asid_q[i]  <= '0;
            tlb_g_q[i]     <= 1'b0;
            tlb_sp_q[i]    <= 1'b0;
            tlb_ppn_q[i]   <= '0;
            tlb_perm_q[i]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         pte_ppn_q <= pte_ppn_d;
         paddr_q   <= paddr_d;
         fault_q   <= fault_d;
         if (accept) begin
            vaddr_q    <= mmu_vaddr_i;
            is_store_q <= mmu_is_store_i;
            is_inst_q  <= mmu_is_inst_i;
            priv_u_q   <= mmu_priv_u_i;
            satp_ppn_q <= mmu_satp_ppn_i[19:0];
            asid_q     <= mmu_satp_asid_i;
         end
         if (mmu_flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) tlb_valid_q[i] <= 1'b0;
         end else if (fill) begin
            tlb_valid_q[victim] <= 1'b1;
            tlb_vpn_q[victim]   <= vaddr_q[31:12];
            tlb_asid_q[victim]  <= asid_q;
            tlb_g_q[victim]     <= pte[5];
            tlb_sp_q[victim]    <= walk_l1;
            tlb_ppn_q[victim]   <= pte[29:10];
            tlb_perm_q[victim]  <= pte_perm;
            if (!has_inv) rr_q <= rr_q + 1'b1;
         end
      end
   end

   assign mmu_resp_valid_o = (state_q == S_RESP);
   assign mmu_paddr_o      = mmu_resp_valid_o ? paddr_q : '0;
   assign mmu_page_fault_o = mmu_resp_valid_o && fault_q;
   assign mmu_mem_req_o    = (state_q == S_WALK1) || (state_q == S_WALK0);
   assign mmu_mem_addr_o   = (state_q == S_WALK1) ? {satp_ppn_q, vaddr_q[31:22], 2'b00} :
                             (state_q == S_WALK0) ? {pte_ppn_q, vaddr_q[21:12], 2'b00} : '0;

endmodule

// File: tb/tb_sv32_itrans.sv
// tb/tb_sv32_itrans.sv - directed vector bench for sv32_itrans
// Table of translation requests plus hand sequences for flush, eviction and reset mid-walk.
module tb_sv32_itrans;
   localparam logic T = 1'b1, F = 1'b0;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] vaddr = '0, rdata = '0;
   logic        req = 1'b0, st = 1'b0, inst = 1'b0, pu = 1'b0, en = 1'b0;
   logic        mxr = 1'b0, sum = 1'b0, rvalid = 1'b0, flush = 1'b0;
   logic [8:0]  asid = '0;
   logic [31:0] paddr, mem_addr;
   logic        resp_valid, fault, mem_req;

   int tests_run = 0, tests_failed = 0;

   typedef struct {
      logic        flush;
      logic        en;
      logic [31:0] vaddr;
      logic        st, inst, pu, mxr, sum;
      logic [8:0]  asid;
      int          lvls;
      logic [31:0] pte1, pte0, a1, a0, paddr;
      logic        fault;
   } vec_t;

   vec_t vecs[18];

   sv32_itrans #(.TLB_ENTRIES(4)) dut (
      .clk(clk), .rst(rst),
      .mmu_vaddr_i(vaddr), .mmu_req_valid_i(req), .mmu_is_store_i(st), .mmu_is_inst_i(inst),
      .mmu_priv_u_i(pu), .mmu_paddr_o(paddr), .mmu_resp_valid_o(resp_valid),
      .mmu_page_fault_o(fault), .mmu_enable_i(en), .mmu_satp_ppn_i(22'h080000),
      .mmu_satp_asid_i(asid), .mmu_mxr_i(mxr), .mmu_sum_i(sum),
      .mmu_mem_req_o(mem_req), .mmu_mem_addr_o(mem_addr), .mmu_mem_rdata_i(rdata),
      .mmu_mem_rvalid_i(rvalid), .mmu_flush_i(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_resp"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_memreq"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_memaddr"}, mem_addr, 32'd0);
      chk({tag, "_paddr"}, paddr, 32'd0);
      chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
   endtask

   // Issue one request, play a 1-cycle-latency memory, check latency, addresses and response.
   task automatic run_vec(input int idx, input vec_t v);
      int  lvl, cyc;
      bit  seen, got;
      if (v.flush) begin
         @(negedge clk); flush = 1'b1;
         @(negedge clk); flush = 1'b0;
      end
      @(negedge clk);
      en = v.en; vaddr = v.vaddr; st = v.st; inst = v.inst; pu = v.pu;
      mxr = v.mxr; sum = v.sum; asid = v.asid; req = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      lvl = 0; cyc = 1; seen = 0; got = 0;
      while (!got && cyc <= 40) begin
         rvalid = 1'b0;
         if (resp_valid) begin
            got = 1;
            chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(1 + 2 * v.lvls));
            chk($sformatf("v%0d_levels", idx), 32'(lvl), 32'(v.lvls));
            chk($sformatf("v%0d_fault", idx), {31'd0, fault}, {31'd0, v.fault});
            if (!v.fault) chk($sformatf("v%0d_paddr", idx), paddr, v.paddr);
         end else begin
            if (mem_req) begin
               if (seen) begin
                  rvalid = 1'b1;
                  rdata  = (lvl == 0) ? v.pte1 : v.pte0;
                  lvl++;
                  seen = 0;
               end else begin
                  seen = 1;
                  if (lvl >= v.lvls) chk($sformatf("v%0d_unexpected_memreq", idx), 32'd1, 32'd0);
                  else chk($sformatf("v%0d_memaddr_l%0d", idx, 1 - lvl), mem_addr,
                           (lvl == 0) ? v.a1 : v.a0);
               end
            end
            @(posedge clk); #1;
            cyc++;
         end
      end
      rvalid = 1'b0;
      if (!got) chk($sformatf("v%0d_resp_timeout", idx), 32'd0, 32'd1);
      else begin
         @(posedge clk); #1;
         chk($sformatf("v%0d_resp_single_pulse", idx), {31'd0, resp_valid}, 32'd0);
      end
   endtask

   function automatic vec_t sp_vec(input int vpn1, input int lvls);
      vec_t v;
      v.flush = F; v.en = T; v.vaddr = (32'(vpn1) << 22) | 32'h56;
      v.st = F; v.inst = F; v.pu = F; v.mxr = F; v.sum = F; v.asid = 9'h0;
      v.lvls = lvls; v.pte1 = 32'h2000_00CF; v.pte0 = 32'h0;
      v.a1 = 32'h8000_0000 + 32'(vpn1) * 4; v.a0 = 32'h0;
      v.paddr = 32'h8000_0056; v.fault = F;
      return v;
   endfunction

   initial begin
      bit   seen_resp;
      vec_t v;
      //          flush en vaddr          st inst pu mxr sum asid  lv pte1           pte0           a1             a0             paddr          fault
      vecs[0]  = '{T, F, 32'h8000_1234, F, F, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_1234, F};
      vecs[1]  = '{T, T, 32'h0040_1ABC, F, F, F, F, F, 9'h0, 2, 32'h2000_0401, 32'h2000_20CB, 32'h8000_0004, 32'h8000_1004, 32'h8000_8ABC, F};
      vecs[2]  = '{F, T, 32'h0040_1ABC, F, F, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_8ABC, F};
      vecs[3]  = '{F, T, 32'h0040_1DEF, F, F, F, F, F, 9'h1, 2, 32'h2000_0401, 32'h2000_20CB, 32'h8000_0004, 32'h8000_1004, 32'h8000_8DEF, F};
      vecs[4]  = '{F, T, 32'h0040_1000, T, F, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         T};
      vecs[5]  = '{F, T, 32'h0040_1004, F, T, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_8004, F};
      vecs[6]  = '{T, T, 32'h0040_0010, F, F, F, F, F, 9'h0, 1, 32'h2000_00CF, 32'h0,         32'h8000_0004, 32'h0,         32'h8000_0010, F};
      vecs[7]  = '{T, T, 32'h0040_0010, F, F, F, F, F, 9'h0, 1, 32'h2000_04CF, 32'h0,         32'h8000_0004, 32'h0,         32'h0,         T};
      vecs[8]  = '{F, T, 32'h0080_0000, F, T, F, F, F, 9'h0, 1, 32'h2000_00C3, 32'h0,         32'h8000_0008, 32'h0,         32'h0,         T};
      vecs[9]  = '{F, T, 32'h00C0_0123, F, F, F, T, F, 9'h0, 1, 32'h2000_00C9, 32'h0,         32'h8000_000C, 32'h0,         32'h8000_0123, F};
      vecs[10] = '{F, T, 32'h00C0_0123, F, F, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         T};
      vecs[11] = '{F, T, 32'h0100_0000, F, T, F, F, F, 9'h0, 1, 32'h2000_00DB, 32'h0,         32'h8000_0010, 32'h0,         32'h0,         T};
      vecs[12] = '{F, T, 32'h0140_0000, T, F, F, F, F, 9'h0, 1, 32'h2000_0047, 32'h0,         32'h8000_0014, 32'h0,         32'h0,         T};
      vecs[13] = '{F, T, 32'h0140_0000, T, F, F, F, F, 9'h0, 1, 32'h2000_0047, 32'h0,         32'h8000_0014, 32'h0,         32'h0,         T};
      vecs[14] = '{F, T, 32'h0100_0444, F, F, T, F, F, 9'h0, 1, 32'h2000_00DB, 32'h0,         32'h8000_0010, 32'h0,         32'h8000_0444, F};
      vecs[15] = '{F, T, 32'h0100_0444, F, F, F, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0,         T};
      vecs[16] = '{F, T, 32'h0100_0444, F, F, F, F, T, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_0444, F};
      vecs[17] = '{F, T, 32'h0100_0444, F, T, T, F, F, 9'h0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         32'h8000_0444, F};

      repeat (2) @(posedge clk);
      #1 chk_idle_outputs("reset");
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // flush while the level-0 read is outstanding
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      en = T; vaddr = 32'h0040_1ABC; st = F; inst = F; pu = F; mxr = F; sum = F; asid = 9'h0; req = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      chk("flush_l1_req", {31'd0, mem_req}, 32'd1);
      chk("flush_l1_addr", mem_addr, 32'h8000_0004);
      @(posedge clk); #1; rvalid = 1'b1; rdata = 32'h2000_0401;
      @(posedge clk); #1; rvalid = 1'b0;
      chk("flush_l0_addr", mem_addr, 32'h8000_1004);
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      chk("flush_req_drop", {31'd0, mem_req}, 32'd0);
      seen_resp = 0;
      for (int k = 0; k < 6; k++) begin
         rvalid = (k == 1);
         rdata  = 32'h2000_20CB;
         if (resp_valid) seen_resp = 1;
         @(posedge clk); #1;
      end
      rvalid = 1'b0;
      chk("flush_no_resp", {31'd0, seen_resp}, 32'd0);
      v = vecs[1]; v.flush = F;
      run_vec(50, v);

      // five distinct superpages through four entries: the first one is evicted
      for (int vpn = 8; vpn <= 12; vpn++) begin
         v = sp_vec(vpn, 1);
         v.flush = (vpn == 8);
         run_vec(100 + vpn, v);
      end
      run_vec(112, sp_vec(12, 0));
      run_vec(109, sp_vec(9, 0));
      run_vec(108, sp_vec(8, 1));

      // reset while the level-1 read is outstanding
      @(negedge clk);
      en = T; vaddr = 32'h0040_1ABC; st = F; inst = F; pu = F; asid = 9'h0; req = 1'b1;
      @(posedge clk); #1; req = 1'b0;
      chk("rst_walk_req", {31'd0, mem_req}, 32'd1);
      #2 rst = 1'b1;
      #1 chk_idle_outputs("rst_mid_walk");
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      run_vec(200, sp_vec(12, 1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
